// File: rtl/tube_host_master.sv
// Host-side bus master: turns local commands into phi2-timed host-bus cycles with stream status polling.
// Latency: one bus period per access; rsp_valid the clock after the final period. Backpressure: cmd_ready only in IDLE.
module tube_host_master #(
  parameter int PHI2_LOW_CYC  = 2,
  parameter int PHI2_HIGH_CYC = 2,
  parameter int POLL_LIMIT    = 255
) (
  input  logic       h_clk,
  input  logic       h_rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [2:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_timeout,
  output logic       h_phi2,
  output logic [2:0] h_addr,
  output logic       h_cs_b,
  output logic       h_rdnw,
  output logic [7:0] h_data_out,
  output logic       h_data_oe,
  input  logic [7:0] h_data_in,
  input  logic       h_irq_b,
  output logic       irq_pending
);

  localparam int PERIOD = PHI2_LOW_CYC + PHI2_HIGH_CYC;
  localparam int PW     = $clog2(PERIOD);
  localparam logic [PW-1:0] PH_LAST = PW'(PERIOD - 1);
  localparam logic [PW-1:0] PH_HIGH = PW'(PHI2_LOW_CYC);

  localparam logic [1:0] OP_RAW_RD = 2'b00;
  localparam logic [1:0] OP_SEND   = 2'b10;
  localparam logic [1:0] OP_RECV   = 2'b11;

  typedef enum logic [2:0] {IDLE, WAIT_SLOT, POLL, DATA, RESP} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] phase_cnt;
  logic          run;
  logic [1:0]    op_q;
  logic [2:0]    addr_q;
  logic [7:0]    wdata_q;
  logic [7:0]    poll_cnt;
  logic [7:0]    poll_cnt_inc;
  logic          irq_s1;

  logic          period_end;
  logic          accept;
  logic          poll_ok;
  logic [2:0]    addr_nxt;
  logic          cs_b_nxt;
  logic          rdnw_nxt;
  logic          rsp_load;
  logic          timeout_nxt;
  logic [7:0]    rsp_data_nxt;
  logic          poll_inc;

  // phase 0 is the first low clock of a period; the period ends on the edge leaving PH_LAST
  assign h_phi2       = (phase_cnt >= PH_HIGH);
  assign period_end   = (phase_cnt == PH_LAST);
  assign cmd_ready    = (state == IDLE) && run && !h_rst;
  assign accept       = cmd_valid && cmd_ready;
  assign rsp_valid    = (state == RESP);
  assign poll_ok      = (op_q == OP_SEND) ? h_data_in[6] : h_data_in[7];
  assign poll_cnt_inc = (poll_cnt == 8'hFF) ? poll_cnt : poll_cnt + 8'd1;
  assign h_data_oe    = !h_cs_b && !h_rdnw && h_phi2;
  assign h_data_out   = h_data_oe ? wdata_q : 8'h00;

  always_comb begin
    state_nxt    = state;
    addr_nxt     = h_addr;
    cs_b_nxt     = 1'b1;
    rdnw_nxt     = 1'b1;
    rsp_load     = 1'b0;
    timeout_nxt  = 1'b0;
    rsp_data_nxt = 8'h00;
    poll_inc     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = WAIT_SLOT;
      end
      WAIT_SLOT: begin
        if (period_end) begin
          cs_b_nxt = 1'b0;
          if (op_q[1]) begin
            state_nxt = POLL;
            addr_nxt  = {addr_q[1:0], 1'b0};
          end else begin
            state_nxt = DATA;
            addr_nxt  = addr_q;
            rdnw_nxt  = (op_q == OP_RAW_RD);
          end
        end
      end
      POLL: begin
        if (period_end) begin
          if (poll_ok) begin
            state_nxt = DATA;
            addr_nxt  = {addr_q[1:0], 1'b1};
            cs_b_nxt  = 1'b0;
            rdnw_nxt  = (op_q == OP_RECV);
          end else begin
            poll_inc = 1'b1;
            if ((POLL_LIMIT != 0) && (int'(poll_cnt_inc) >= POLL_LIMIT)) begin
              state_nxt    = RESP;
              rsp_load     = 1'b1;
              timeout_nxt  = 1'b1;
              rsp_data_nxt = h_data_in;
            end else begin
              cs_b_nxt = 1'b0;
            end
          end
        end
      end
      DATA: begin
        if (period_end) begin
          state_nxt    = RESP;
          rsp_load     = 1'b1;
          rsp_data_nxt = h_rdnw ? h_data_in : 8'h00;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge h_clk) begin
    if (h_rst) begin
      state       <= IDLE;
      phase_cnt   <= '0;
      run         <= 1'b0;
      h_addr      <= 3'd0;
      h_cs_b      <= 1'b1;
      h_rdnw      <= 1'b1;
      op_q        <= 2'b00;
      addr_q      <= 3'd0;
      wdata_q     <= 8'h00;
      poll_cnt    <= 8'h00;
      rsp_data    <= 8'h00;
      rsp_timeout <= 1'b0;
      irq_s1      <= 1'b0;
      irq_pending <= 1'b0;
    end else begin
      state <= state_nxt;
      run   <= 1'b1;
      // hold phase 0 on the first clock out of reset so a low phase starts immediately
      phase_cnt <= (!run || period_end) ? '0 : phase_cnt + PW'(1);
      if (period_end) begin
        h_addr <= addr_nxt;
        h_cs_b <= cs_b_nxt;
        h_rdnw <= rdnw_nxt;
      end
      if (accept) begin
        op_q     <= cmd_op;
        addr_q   <= cmd_addr;
        wdata_q  <= cmd_wdata;
        poll_cnt <= 8'h00;
      end else if (poll_inc) begin
        poll_cnt <= poll_cnt_inc;
      end
      if (rsp_load) begin
        rsp_data    <= rsp_data_nxt;
        rsp_timeout <= timeout_nxt;
      end
      irq_s1      <= !h_irq_b;
      irq_pending <= irq_s1;
    end
  end

endmodule
